// File: rtl/pipe_vshift.sv
// Pipelined variable shifter (right/left; logical, arithmetic, rotate) with a
// global-stall valid/ready handshake. Optional sticky output under `VSHIFT_STICKY_EN.
module pipe_vshift #(
  parameter  int DW  = 32,
  localparam int SHW = $clog2(DW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [SHW-1:0] in_shift,
  input  logic           in_dir,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_sticky
);

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  function automatic logic [DW-1:0] shift_step(input logic [DW-1:0] d, input int amt,
                                               input logic dir, input logic [1:0] mode,
                                               input logic sign);
    logic [2*DW-1:0] w;
    w = '0;
    if (mode == MODE_ROT) begin
      if (dir) begin
        w = {d, d} << amt;
        shift_step = w[2*DW-1:DW];
      end else begin
        w = {d, d} >> amt;
        shift_step = w[DW-1:0];
      end
    end else if (dir) begin
      shift_step = d << amt;
    end else if (mode == MODE_ARITH) begin
      w = {{DW{sign}}, d} >> amt;
      shift_step = w[DW-1:0];
    end else begin
      shift_step = d >> amt;
    end
  endfunction

  logic [DW-1:0]  data_q [SHW];
  logic [DW-1:0]  data_d [SHW];
  logic [SHW-1:0] shamt_q [SHW];
  logic [1:0]     mode_q [SHW];
  logic           dir_q [SHW];
  logic           sign_q [SHW];
  logic           vld_q [SHW];

  logic [DW-1:0]  src_data [SHW];
  logic [SHW-1:0] src_shamt [SHW];
  logic [1:0]     src_mode [SHW];
  logic           src_dir [SHW];
  logic           src_sign [SHW];
  logic           src_vld [SHW];

  logic stall;

  assign stall     = vld_q[SHW-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];

  // Stage k consumes stage k-1 (stage 0 consumes the input port) and applies 2^k.
  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shift;
    src_mode[0]  = in_mode;
    src_dir[0]   = in_dir;
    src_sign[0]  = in_data[DW-1];
    src_vld[0]   = in_valid;
    for (int k = 1; k < SHW; k++) begin
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_dir[k]   = dir_q[k-1];
      src_sign[k]  = sign_q[k-1];
      src_vld[k]   = vld_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      data_d[k] = src_shamt[k][k] ? shift_step(src_data[k], 1 << k, src_dir[k], src_mode[k], src_sign[k])
                                  : src_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        dir_q[k]   <= 1'b0;
        sign_q[k]  <= 1'b0;
        vld_q[k]   <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= src_shamt[k];
        mode_q[k]  <= src_mode[k];
        dir_q[k]   <= src_dir[k];
        sign_q[k]  <= src_sign[k];
        vld_q[k]   <= src_vld[k];
      end
    end
  end

`ifdef VSHIFT_STICKY_EN
  // Only right logical/arithmetic shifts discard bits worth remembering.
  function automatic logic lost_bits(input logic [DW-1:0] d, input int amt,
                                     input logic dir, input logic [1:0] mode);
    logic [DW-1:0] mask;
    mask = ~({DW{1'b1}} << amt);
    if (dir || mode == MODE_ROT) lost_bits = 1'b0;
    else                         lost_bits = |(d & mask);
  endfunction

  logic sticky_q [SHW];
  logic sticky_d [SHW];
  logic src_sticky [SHW];

  always_comb begin
    src_sticky[0] = 1'b0;
    for (int k = 1; k < SHW; k++) src_sticky[k] = sticky_q[k-1];
    for (int k = 0; k < SHW; k++) begin
      sticky_d[k] = src_sticky[k] |
                    (src_shamt[k][k] & lost_bits(src_data[k], 1 << k, src_dir[k], src_mode[k]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) sticky_q[k] <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) sticky_q[k] <= sticky_d[k];
    end
  end

  assign out_sticky = sticky_q[SHW-1];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_vshift.sv
// Directed bench for pipe_vshift at DW=8: hand vectors, mode/direction sweep,
// random stream with a mid-stream stall, and asynchronous reset with a full pipe.
module tb_pipe_vshift;
  localparam int DW  = 8;
  localparam int SHW = 3;
`ifdef VSHIFT_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [SHW-1:0] in_shift;
  logic           in_dir;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_vshift #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-by-bit reference: returns {sticky, data}.
  function automatic logic [DW:0] model(input logic [DW-1:0] d, input int s,
                                        input logic dr, input logic [1:0] m);
    logic [DW-1:0] r;
    logic          st;
    r  = '0;
    st = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (m == 2'b10)  r[i] = dr ? d[(i - s + DW) % DW] : d[(i + s) % DW];
      else if (dr)     r[i] = (i >= s) ? d[i - s] : 1'b0;
      else             r[i] = (i + s < DW) ? d[i + s] : ((m == 2'b01) ? d[DW-1] : 1'b0);
    end
    if (!dr && m != 2'b10)
      for (int i = 0; i < s; i++) st = st | d[i];
    return {st & STK, r};
  endfunction

  // One isolated beat; checks exact latency, data and sticky.
  task automatic one(input string tag, input logic [DW-1:0] d, input int s, input logic dr,
                     input logic [1:0] m, input logic [DW-1:0] exp_d, input logic exp_s);
    in_data = d; in_shift = s[SHW-1:0]; in_dir = dr; in_mode = m;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (SHW - 2) step();
    check({tag, "_early"}, out_valid, 1'b0);
    step();
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sticky"}, out_sticky, exp_s & STK);
    step();
  endtask

  logic [DW-1:0]  b_data [16];
  logic [SHW-1:0] b_shift [16];
  logic           b_dir [16];
  logic [1:0]     b_mode [16];
  logic [DW:0]    expq [$];
  logic [DW:0]    e;
  logic [DW-1:0]  held;
  int idx, received;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
    in_mode = 2'b00; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_sticky", out_sticky, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Hand-computed directed vectors
    one("rl_b4_3",    8'hB4, 3, 1'b0, 2'b00, 8'h16, 1'b1);
    one("ra_90_2",    8'h90, 2, 1'b0, 2'b01, 8'hE4, 1'b0);
    one("ra_10_2",    8'h10, 2, 1'b0, 2'b01, 8'h04, 1'b0);
    one("rotl_81_1",  8'h81, 1, 1'b1, 2'b10, 8'h03, 1'b0);
    one("rotr_81_7",  8'h81, 7, 1'b0, 2'b10, 8'h03, 1'b0);
    one("m11_b4_3",   8'hB4, 3, 1'b0, 2'b11, 8'h16, 1'b1);
    one("ll_b4_3",    8'hB4, 3, 1'b1, 2'b00, 8'hA0, 1'b0);
    one("rl_b4_0",    8'hB4, 0, 1'b0, 2'b00, 8'hB4, 1'b0);

    // Shift 0 and DW-1 in every mode and direction against the model
    for (int m = 0; m < 4; m++)
      for (int dr = 0; dr < 2; dr++)
        for (int s = 0; s < DW; s += DW - 1) begin
          e = model(8'hA5, s, dr[0], m[1:0]);
          one($sformatf("sweep_m%0d_d%0d_s%0d", m, dr, s), 8'hA5, s, dr[0], m[1:0], e[DW-1:0], e[DW]);
        end

    // Random back-to-back stream with a 5-cycle output stall at cycle 8
    for (int i = 0; i < 16; i++) begin
      b_data[i]  = $urandom_range(255, 0);
      b_shift[i] = $urandom_range(7, 0);
      b_dir[i]   = $urandom_range(1, 0);
      b_mode[i]  = $urandom_range(3, 0);
    end
    idx = 0; received = 0; held = '0;
    for (int cyc = 0; cyc < 100 && received < 16; cyc++) begin
      in_valid = (idx < 16);
      if (idx < 16) begin
        in_data = b_data[idx]; in_shift = b_shift[idx]; in_dir = b_dir[idx]; in_mode = b_mode[idx];
      end
      out_ready = !(cyc >= 8 && cyc < 13);
      #1;
      if (cyc == 8) begin
        check("stream_accepted_before_stall", idx, 8);
        held = out_data;
      end
      if (cyc >= 8 && cyc < 13) begin
        check($sformatf("stall_in_ready_c%0d", cyc), in_ready, 1'b0);
        check($sformatf("stall_out_valid_c%0d", cyc), out_valid, 1'b1);
        check($sformatf("stall_out_data_c%0d", cyc), out_data, held);
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(b_data[idx], int'(b_shift[idx]), b_dir[idx], b_mode[idx]));
        idx++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("stream_unexpected_output", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check($sformatf("stream_data_%0d", received), out_data, e[DW-1:0]);
          check($sformatf("stream_sticky_%0d", received), out_sticky, e[DW]);
        end
        received++;
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_received", received, 16);
    check("stream_queue_empty", expq.size(), 0);
    check("stream_drained", out_valid, 1'b0);

    // Fill the pipe, then asynchronous reset mid-stream
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_shift = 3'd1;
    in_dir = 1'b0; in_mode = 2'b00;
    repeat (SHW + 1) step();
    check("full_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out_data", out_data, 8'h00);
    check("async_rst_out_sticky", out_sticky, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    one("post_rst_beat", 8'h3C, 2, 1'b0, 2'b00, 8'h0F, 1'b0);
    check("post_rst_no_extra", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
